// File: rtl/add8_frame_accum_pkg.sv
// Shared types and constants for the 8-bit frame accumulator and its adder stage.
package add8_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [DEFAULT_DATA_W-1:0] SAT_MAX = 8'h7F;
    localparam logic [DEFAULT_DATA_W-1:0] SAT_MIN = 8'h80;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Two's-complement overflow: operands share a sign that the result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add8_frame_accum_if.sv
// Sample-in / frame-result-out stream pair of the frame accumulator.
interface add8_frame_accum_if
    import add8_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );
endinterface

// File: rtl/add8_frame_accum_ovf.sv
// Combinational two's-complement adder with signed-overflow flag.
module add8_ovf
    import add8_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         ovf
);
    always_comb begin
        s   = a + b;
        ovf = add_ovf(a[W-1], b[W-1], s[W-1]);
    end
endmodule

// File: rtl/add8_frame_accum.sv
// Per-frame signed accumulator with sticky overflow, optional saturation and a
// one-deep registered result slot released by the output handshake.
module add8_frame_accum
    import add8_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int CNT_W    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              aresetn,
    add8_frame_accum_if.slave bus
);
    localparam logic [DATA_W-1:0] SAT_HI  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_LO  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic              ovf_st;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;

    add8_ovf #(.W(DATA_W)) u_add (
        .a   (acc),
        .b   (bus.in_data),
        .s   (sum),
        .ovf (ovf)
    );

    // Both handshake outputs come straight from the state register.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign accept        = bus.in_valid && (state == ACCUM);

    always_comb begin
        acc_nxt = sum;
        if (SATURATE && ovf) begin
            acc_nxt = acc[DATA_W-1] ? SAT_LO : SAT_HI;
        end
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && bus.in_last) state_nxt = HOLD;
            HOLD:  if (bus.out_ready)         state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc           <= '0;
            ovf_st        <= 1'b0;
            cnt           <= '0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_count <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                // Result slot captures the post-sample totals; the next frame starts clean.
                bus.out_sum   <= acc_nxt;
                bus.out_ovf   <= ovf_st | ovf;
                bus.out_count <= cnt_nxt;
                acc           <= '0;
                ovf_st        <= 1'b0;
                cnt           <= '0;
            end else begin
                acc    <= acc_nxt;
                ovf_st <= ovf_st | ovf;
                cnt    <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_add8_frame_accum.sv
// Drives saturating and wrapping accumulators with one stream and compares each
// frame result against an integer-arithmetic model of the frame sum.
module tb_add8_frame_accum;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
        logic [3:0] count;
    } result_t;

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    add8_frame_accum_if #(.DATA_W(8), .CNT_W(4)) bus_s ();
    add8_frame_accum_if #(.DATA_W(8), .CNT_W(4)) bus_w ();

    add8_frame_accum #(.DATA_W(8), .CNT_W(4), .SATURATE(1'b1)) dut_sat (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus_s)
    );

    add8_frame_accum #(.DATA_W(8), .CNT_W(4), .SATURATE(1'b0)) dut_wrap (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus_w)
    );

    always #5 clk = ~clk;

    // Frame sum in plain integers: overflow means leaving the signed 8-bit range.
    function automatic result_t model(input logic [7:0] samples[$], input bit sat);
        result_t r;
        int acc = 0;
        r.ovf = 1'b0;
        foreach (samples[i]) begin
            int t = acc + int'($signed(samples[i]));
            if (t > 127 || t < -128) begin
                r.ovf = 1'b1;
                if (sat) t = (t > 127) ? 127 : -128;
                else     t = (t > 127) ? t - 256 : t + 256;
            end
            acc = t;
        end
        r.sum   = acc[7:0];
        r.count = (samples.size() > 15) ? 4'd15 : 4'(samples.size());
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input bit sat, input logic v, input logic r,
                             input logic [7:0] s, input logic o, input logic [3:0] c);
        string      t;
        logic       v_o, r_o, o_o;
        logic [7:0] s_o;
        logic [3:0] c_o;
        if (sat) begin
            t = {tag, ".sat"};
            v_o = bus_s.out_valid; r_o = bus_s.in_ready; s_o = bus_s.out_sum;
            o_o = bus_s.out_ovf;   c_o = bus_s.out_count;
        end else begin
            t = {tag, ".wrap"};
            v_o = bus_w.out_valid; r_o = bus_w.in_ready; s_o = bus_w.out_sum;
            o_o = bus_w.out_ovf;   c_o = bus_w.out_count;
        end
        check_output({t, ".out_valid"}, 32'(v_o), 32'(v));
        check_output({t, ".in_ready"},  32'(r_o), 32'(r));
        check_output({t, ".out_sum"},   32'(s_o), 32'(s));
        check_output({t, ".out_ovf"},   32'(o_o), 32'(o));
        check_output({t, ".out_count"}, 32'(c_o), 32'(c));
    endtask

    task automatic check_idle(input string tag);
        check_bus(tag, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
        check_bus(tag, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
    endtask

    task automatic set_inputs(input logic v, input logic [7:0] d, input logic l, input logic r);
        bus_s.in_valid = v; bus_s.in_data = d; bus_s.in_last = l; bus_s.out_ready = r;
        bus_w.in_valid = v; bus_w.in_data = d; bus_w.in_last = l; bus_w.out_ready = r;
    endtask

    // One frame: optional idle gaps between samples, then `hold` cycles of
    // backpressure (with a junk sample offered) before the result is taken.
    task automatic apply_stimulus(input string tag, input logic [7:0] samples[$],
                                  input bit gaps, input int hold);
        result_t es = model(samples, 1'b1);
        result_t ew = model(samples, 1'b0);
        int      idx = 0;
        bit      pres;
        while (idx < samples.size()) begin
            pres = !(gaps && $urandom_range(0, 3) == 0);
            set_inputs(pres, pres ? samples[idx] : 8'($urandom),
                       pres ? (idx == samples.size() - 1) : 1'($urandom), 1'($urandom));
            check_output({tag, ".accum.in_ready"},  32'({bus_s.in_ready, bus_w.in_ready}), 32'd3);
            check_output({tag, ".accum.out_valid"}, 32'({bus_s.out_valid, bus_w.out_valid}), 32'd0);
            @(posedge clk); #1;
            if (pres) idx++;
        end
        for (int c = 0; c <= hold; c++) begin
            set_inputs(1'b1, 8'($urandom), 1'($urandom), c == hold);
            check_bus({tag, ".hold"}, 1'b1, 1'b1, 1'b0, es.sum, es.ovf, es.count);
            check_bus({tag, ".hold"}, 1'b0, 1'b1, 1'b0, ew.sum, ew.ovf, ew.count);
            @(posedge clk); #1;
        end
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
        check_output({tag, ".post.out_valid"}, 32'({bus_s.out_valid, bus_w.out_valid}), 32'd0);
        check_output({tag, ".post.in_ready"},  32'({bus_s.in_ready, bus_w.in_ready}), 32'd3);
    endtask

    initial begin
        logic [7:0] q[$];
        int         len;

        $display("[TB] start");
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        aresetn = 1'b1;
        @(posedge clk); #1;
        check_idle("released");

        q = '{8'h50, 8'h50};
        apply_stimulus("pos_ovf", q, 1'b0, 0);
        q = '{8'h7F, 8'h80};
        apply_stimulus("mixed_ok", q, 1'b0, 3);
        q = '{8'h80, 8'hFF};
        apply_stimulus("neg_ovf", q, 1'b1, 1);
        q = '{8'hC3};
        apply_stimulus("single", q, 1'b0, 0);
        q.delete();
        repeat (20) q.push_back(8'h01);
        apply_stimulus("cnt_sat", q, 1'b0, 2);

        for (int f = 0; f < 10; f++) begin
            q.delete();
            len = $urandom_range(1, 20);
            repeat (len) q.push_back(8'($urandom));
            apply_stimulus($sformatf("rand%0d", f), q, 1'b1, $urandom_range(0, 3));
        end

        // Reset mid-frame after a nonzero result has been delivered.
        q = '{8'h33};
        apply_stimulus("pre_rst", q, 1'b0, 0);
        set_inputs(1'b1, 8'h10, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_inputs(1'b1, 8'h20, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        check_idle("rst_mid");
        @(posedge clk); #1;
        aresetn = 1'b1;
        q = '{8'h05};
        apply_stimulus("after_rst", q, 1'b0, 0);

        // Reset while a result is pending.
        set_inputs(1'b1, 8'h44, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("rst_hold.pending", 32'({bus_s.out_valid, bus_w.out_valid}), 32'd3);
        aresetn = 1'b0;
        #1;
        check_idle("rst_hold");
        @(posedge clk); #1;
        aresetn = 1'b1;
        q = '{8'hF0, 8'hF0, 8'h01};
        apply_stimulus("after_rst2", q, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
